dec38_seq: RTL and testbench
============================

# dec38_seq

Sequenced 3-to-8 one-hot decoder: the companion to the team's 8:3 priority encoder. It accepts 3-bit codes over a valid/ready handshake and buffers one code while another is being driven. Each accepted code is driven as a one-hot line on `y` for a programmable number of cycles. It sits downstream of the encoder, turning encoded indices back into timed one-hot select/strobe lines.

## Interface
- `HOLD`, default 4: cycles each one-hot code is driven; legal range 1..255.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_code` is valid this cycle.
- `in_code` input 3: code to decode; bit 2 is MSB.
- `in_ready` output 1: block can accept a code this cycle.
- `y` output 8: one-hot decoded output; `y[i]`=1 for code i; all-zero when idle.
- `busy` output 1: a code is currently being driven (state DRIVE).
- `done` output 1: high during the final hold cycle of each driven code.

## Operation
- Storage: one-entry pending register (`pend_code`, `pend_full`); one active register (`act_code`); hold counter `cnt`, 8 bits.
- `in_ready` = !`pend_full` && !`rst`.
- Accept: when `in_valid` && `in_ready` at an edge, `pend_code` <= `in_code` and `pend_full` <= 1. When `in_ready`=0, `in_code` is ignored.
- FSM states: IDLE, DRIVE.
  - IDLE and `pend_full`=1: go to DRIVE. Set `act_code` <= `pend_code`, `cnt` <= HOLD-1, `pend_full` <= 0.
  - DRIVE and `cnt`!=0: `cnt` decrements by 1.
  - DRIVE, `cnt`==0, `pend_full`=1: reload as in IDLE and stay in DRIVE. The next code follows with no gap.
  - DRIVE, `cnt`==0, `pend_full`=0: go to IDLE.
- Outputs are derived from registers only; there is no combinational path from inputs.
  - `y` = (state==DRIVE) ? (8'b1 << `act_code`) : 8'h00.
  - `busy` = (state==DRIVE).
  - `done` = (state==DRIVE && `cnt`==0).
- An accept into an empty pending register while in IDLE is not bypassed. The code always passes through the pending register.
- The pending register drains and is refilled on different edges, because `in_ready` is low while `pend_full`=1.

## Timing
- Reset: when `rst`=1 at an edge, set state=IDLE, `pend_full`=0, `cnt`=0, `act_code`=0.
  - After that edge: `y`=8'h00, `busy`=0, `done`=0, `in_ready`=1.
  - During any cycle with `rst`=1, `in_ready`=0.
- Latency: code accepted at edge k appears on `y` after edge k+1 (from IDLE).
- Duration: each code drives `y` for exactly HOLD cycles. `done` is high only in the last of those cycles.
- Streaming with HOLD>=2: the next code is accepted while the current one is driven, and successive codes appear on `y` back-to-back with no all-zero cycle.
- Streaming with HOLD=1: one code per 2 cycles. Each driven cycle is followed by one all-zero cycle.
- Simultaneous events:
  - Final hold cycle with `pend_full`=1: the pending code is loaded and `pend_full` clears on the same edge.
  - A new accept cannot occur on that edge (`in_ready`=0).
- Reset mid-DRIVE:
  - `y` goes to 8'h00 after the reset edge.
  - The pending code is discarded.
  - `done` is not asserted for the aborted code.
- `y` is never multi-hot. `y` is never nonzero outside DRIVE.

## Test plan
- Reset: assert `rst` 2 cycles with `in_valid`=1, `in_code`=5 -> `in_ready`=0 during reset. After release: `y`=8'h00, `busy`=0, `done`=0, `in_ready`=1, and no code was accepted.
- Single code, HOLD=4: accept `in_code`=3 at edge k -> `y`=8'h08 for cycles after edges k+1..k+4, `done`=1 only in the 4th, then `y`=8'h00 and `busy`=0.
- Streaming, HOLD=4: present codes 0,7,2 with `in_valid` held and honour `in_ready` -> `y` sequence is 8'h01 x4, 8'h80 x4, 8'h04 x4 with no zero gap, and `done` pulses 3 times.
- Streaming, HOLD=1: present codes 1,6 back-to-back -> `y` = 8'h02, 8'h00, 8'h40. `in_ready` is low the cycle after each accept.
- Backpressure: while in DRIVE with `pend_full`=1, toggle `in_code` 0..7 with `in_valid`=1 -> none accepted. The pending value driven next is the one captured first.
- Reset mid-operation: `rst` pulsed at the 2nd hold cycle of code 4 while code 5 is pending -> `y`=8'h00 next cycle, no `done`, and code 5 never appears.

Source files
------------

// File: rtl/dec38_seq.sv
// dec38_seq: sequenced 3-to-8 one-hot decoder.
// Each accepted 3-bit code passes through a one-entry pending register and is
// then driven as a one-hot line on y for HOLD cycles. While one code is being
// driven, the next one can already wait in the pending register, so codes
// follow each other on y with no idle gap when HOLD >= 2.
//
// Handshake: a code transfers on a rising edge where in_valid && in_ready are
// both high. in_ready depends only on pend_full and rst and never on in_valid.
// The producer must hold in_code stable while in_valid is high and in_ready is
// low. Codes offered while in_ready is low are ignored and not stored.
module dec38_seq #(
    parameter int unsigned HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    output logic       in_ready,
    output logic [7:0] y,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // The counter reloads to HOLD-1 so that a code is driven for exactly HOLD
    // cycles, counting down to zero on its final cycle.
    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

    state_t     state;
    state_t     state_nx;
    logic [2:0] pend_code;
    logic       pend_full;
    logic [2:0] act_code;
    logic [7:0] cnt;
    logic       accept;
    logic       load;
    logic       last_cycle;

    assign in_ready   = !pend_full && !rst;
    assign accept     = in_valid && in_ready;
    assign last_cycle = (state == DRIVE) && (cnt == 8'd0);

    // Next-state logic: move the pending code into the active register whenever
    // the decoder is idle or is finishing its current code.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend_full) begin
                    state_nx = DRIVE;
                    load     = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt == 8'd0) begin
                    if (pend_full) begin
                        state_nx = DRIVE;
                        load     = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, pending, active and hold-counter registers. A load and an accept
    // can never share an edge because a load needs pend_full=1, which holds
    // in_ready low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend_full <= 1'b0;
            pend_code <= 3'd0;
            act_code  <= 3'd0;
            cnt       <= 8'd0;
        end else begin
            state <= state_nx;
            if (load) begin
                act_code  <= pend_code;
                cnt       <= HOLD_M1;
                pend_full <= 1'b0;
            end else begin
                if (state == DRIVE && cnt != 8'd0) begin
                    cnt <= cnt - 8'd1;
                end
                if (accept) begin
                    pend_code <= in_code;
                    pend_full <= 1'b1;
                end
            end
        end
    end

    // Outputs come from registers only, so there is no input-to-y path.
    always_comb begin
        busy = (state == DRIVE);
        done = last_cycle;
        y    = 8'h00;
        if (state == DRIVE) begin
            y = 8'h01 << act_code;
        end
    end

endmodule

// File: tb/tb_dec38_seq.sv
// tb_dec38_seq: checks dec38_seq with HOLD=4 and HOLD=1 against a timeline
// model. Each accepted code gets a scheduled drive window [s, s+HOLD-1], where
// s = max(accept_edge + 1, end of previous window + 1), and the code sits in
// the pending register from its accept edge up to s.
module tb_dec38_seq;

  typedef struct packed {
    logic [2:0] code;
    int         k;
    int         s;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'd0;

  logic       ready4, busy4, done4;
  logic [7:0] y4;
  logic       ready1, busy1, done1;
  logic [7:0] y1;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   known = 1'b0;
  ent_t q4[$];
  ent_t q1[$];

  dec38_seq #(.HOLD(4)) u_h4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
    .in_ready(ready4), .y(y4), .busy(busy4), .done(done4)
  );

  dec38_seq #(.HOLD(1)) u_h1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
    .in_ready(ready1), .y(y1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_ready(input ent_t q[$], input int c);
    foreach (q[i]) if (q[i].k <= c && c < q[i].s) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] m_y(input ent_t q[$], input int h, input int c);
    foreach (q[i]) if (c >= q[i].s && c <= q[i].s + h - 1) return 8'(1 << q[i].code);
    return 8'h00;
  endfunction

  function automatic bit m_done(input ent_t q[$], input int h, input int c);
    foreach (q[i]) if (c == q[i].s + h - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_free(input ent_t q[$], input int h);
    if (q.size() == 0) return 0;
    return q[q.size() - 1].s + h;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%02h expected=%02h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    if (known) begin
      chk("y_h4", y4, m_y(q4, 4, cyc));
      chk("busy_h4", {7'd0, busy4}, {7'd0, m_y(q4, 4, cyc) != 8'h00});
      chk("done_h4", {7'd0, done4}, {7'd0, m_done(q4, 4, cyc)});
      chk("ready_h4", {7'd0, ready4}, {7'd0, !rst && m_ready(q4, cyc)});
      chk("onehot_h4", {7'd0, $countones(y4) <= 1}, 8'd1);
      chk("y_h1", y1, m_y(q1, 1, cyc));
      chk("busy_h1", {7'd0, busy1}, {7'd0, m_y(q1, 1, cyc) != 8'h00});
      chk("done_h1", {7'd0, done1}, {7'd0, m_done(q1, 1, cyc)});
      chk("ready_h1", {7'd0, ready1}, {7'd0, !rst && m_ready(q1, cyc)});
      chk("onehot_h1", {7'd0, $countones(y1) <= 1}, 8'd1);
    end else if (rst) begin
      chk("ready_h4_in_reset", {7'd0, ready4}, 8'd0);
      chk("ready_h1_in_reset", {7'd0, ready1}, 8'd0);
    end
  endtask

  // Advance the model across one rising edge using the inputs just sampled.
  task automatic update_models(output bit a4, output bit a1);
    ent_t e;
    a4 = 1'b0;
    a1 = 1'b0;
    if (rst) begin
      q4.delete();
      q1.delete();
      known = 1'b1;
    end else if (known && in_valid) begin
      if (m_ready(q4, cyc)) begin
        e.code = in_code;
        e.k = cyc + 1;
        e.s = (cyc + 2 > m_free(q4, 4)) ? cyc + 2 : m_free(q4, 4);
        q4.push_back(e);
        a4 = 1'b1;
      end
      if (m_ready(q1, cyc)) begin
        e.code = in_code;
        e.k = cyc + 1;
        e.s = (cyc + 2 > m_free(q1, 1)) ? cyc + 2 : m_free(q1, 1);
        q1.push_back(e);
        a1 = 1'b1;
      end
    end
    cyc++;
    while (q4.size() > 1 && q4[0].s + 3 < cyc) void'(q4.pop_front());
    while (q1.size() > 1 && q1[0].s < cyc) void'(q1.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic v, input logic [2:0] code,
                      output bit a4, output bit a1);
    @(negedge clk);
    rst = r;
    in_valid = v;
    in_code = code;
    #1;
    check_all();
    @(posedge clk);
    update_models(a4, a1);
  endtask

  task automatic idle(input int n);
    bit a4, a1;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, a4, a1);
  endtask

  // Offer a code with in_valid held until the chosen instance takes it.
  task automatic send(input logic [2:0] code, input bit use1, input string tag);
    bit a4, a1;
    int n;
    n = 0;
    do begin
      step(1'b0, 1'b1, code, a4, a1);
      n++;
    end while (!(use1 ? a1 : a4) && n < 20);
    chk({tag, "_accepted"}, {7'd0, use1 ? a1 : a4}, 8'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit a4, a1;

    // Reset held two cycles with a code offered; nothing may be accepted.
    step(1'b1, 1'b1, 3'd5, a4, a1);
    step(1'b1, 1'b1, 3'd5, a4, a1);
    idle(3);

    // Single code.
    send(3'd3, 1'b0, "single3");
    idle(7);

    // Streaming with HOLD=4 pacing.
    send(3'd0, 1'b0, "stream0");
    send(3'd7, 1'b0, "stream7");
    send(3'd2, 1'b0, "stream2");
    idle(16);

    // Streaming with HOLD=1 pacing.
    send(3'd1, 1'b1, "fast1");
    send(3'd6, 1'b1, "fast6");
    idle(10);

    // Backpressure: toggle the code while the pending register is full.
    send(3'd2, 1'b0, "bp_first");
    send(3'd4, 1'b0, "bp_pending");
    step(1'b0, 1'b1, 3'd7, a4, a1);
    step(1'b0, 1'b1, 3'd0, a4, a1);
    step(1'b0, 1'b1, 3'd1, a4, a1);
    idle(14);

    // Reset during the second hold cycle of code 4 with code 5 pending.
    send(3'd4, 1'b0, "rst_active");
    send(3'd5, 1'b0, "rst_pending");
    step(1'b1, 1'b0, 3'd0, a4, a1);
    idle(8);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), a4, a1);
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
